// File: rtl/spectrum_bar_smoother.sv
// Turns each 16-bin spectrum frame into smoothed bar heights, published atomically with valid.
// Define SPECTRUM_PEAK_HOLD_EN to build per-bin peak-hold markers; otherwise p* mirrors h*.
module spectrum_bar_smoother #(
    parameter int unsigned SHIFT       = 12,
    parameter int unsigned BAR_MAX     = 448,
    parameter int unsigned DECAY       = 4,
    parameter int unsigned HOLD_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        done,
    input  logic [23:0] f0,
    input  logic [23:0] f1,
    input  logic [23:0] f2,
    input  logic [23:0] f3,
    input  logic [23:0] f4,
    input  logic [23:0] f5,
    input  logic [23:0] f6,
    input  logic [23:0] f7,
    input  logic [23:0] f8,
    input  logic [23:0] f9,
    input  logic [23:0] f10,
    input  logic [23:0] f11,
    input  logic [23:0] f12,
    input  logic [23:0] f13,
    input  logic [23:0] f14,
    input  logic [23:0] f15,
    output logic [8:0]  h0,
    output logic [8:0]  h1,
    output logic [8:0]  h2,
    output logic [8:0]  h3,
    output logic [8:0]  h4,
    output logic [8:0]  h5,
    output logic [8:0]  h6,
    output logic [8:0]  h7,
    output logic [8:0]  h8,
    output logic [8:0]  h9,
    output logic [8:0]  h10,
    output logic [8:0]  h11,
    output logic [8:0]  h12,
    output logic [8:0]  h13,
    output logic [8:0]  h14,
    output logic [8:0]  h15,
    output logic [8:0]  p0,
    output logic [8:0]  p1,
    output logic [8:0]  p2,
    output logic [8:0]  p3,
    output logic [8:0]  p4,
    output logic [8:0]  p5,
    output logic [8:0]  p6,
    output logic [8:0]  p7,
    output logic [8:0]  p8,
    output logic [8:0]  p9,
    output logic [8:0]  p10,
    output logic [8:0]  p11,
    output logic [8:0]  p12,
    output logic [8:0]  p13,
    output logic [8:0]  p14,
    output logic [8:0]  p15,
    output logic        valid,
    output logic        busy
);

    if (BAR_MAX >= 512) begin : g_bad_bar_max
        $error("BAR_MAX must be below 512");
    end
    if (HOLD_FRAMES > 255) begin : g_bad_hold_frames
        $error("HOLD_FRAMES must fit in 8 bits");
    end

    localparam logic [8:0] BarMax = 9'(BAR_MAX);
    localparam logic [8:0] Decay  = 9'(DECAY);

    typedef enum logic [1:0] {StIdle, StProc, StPublish} state_e;

    state_e            r_state;
    logic              r_done_q;
    logic              r_pending;
    logic              r_valid;
    logic [3:0]        r_idx;
    logic [15:0][23:0] r_snap;
    logic [15:0][8:0]  r_wh;
    logic [15:0][8:0]  r_h;

    logic [15:0][23:0] w_f;
    logic [15:0][8:0]  w_p;
    logic              w_start;
    logic [23:0]       w_cur;
    logic [23:0]       w_shift;
    logic [8:0]        w_t;
    logic [8:0]        w_wh_old;
    logic [8:0]        w_wh_new;

    assign w_f = {f15, f14, f13, f12, f11, f10, f9, f8, f7, f6, f5, f4, f3, f2, f1, f0};
    assign w_start = done & ~r_done_q;

    // Saturate at full width so large bins never wrap into small heights.
    always_comb begin
        w_cur    = r_snap[r_idx];
        w_shift  = w_cur >> SHIFT;
        w_t      = (w_shift > 24'(BAR_MAX)) ? BarMax : w_shift[8:0];
        w_wh_old = r_wh[r_idx];
        if (w_t >= w_wh_old) begin
            w_wh_new = w_t;
        end else if ((w_wh_old > Decay) && ((w_wh_old - Decay) > w_t)) begin
            w_wh_new = w_wh_old - Decay;
        end else begin
            w_wh_new = w_t;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StIdle;
            r_done_q  <= 1'b0;
            r_pending <= 1'b0;
            r_valid   <= 1'b0;
            r_idx     <= 4'd0;
            r_snap    <= '0;
            r_wh      <= '0;
            r_h       <= '0;
        end else begin
            r_done_q <= done;
            r_valid  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_start) begin
                        r_snap  <= w_f;
                        r_idx   <= 4'd0;
                        r_state <= StProc;
                    end
                end
                StProc: begin
                    r_wh[r_idx] <= w_wh_new;
                    r_idx       <= r_idx + 4'd1;
                    if (w_start) r_pending <= 1'b1;
                    if (r_idx == 4'd15) r_state <= StPublish;
                end
                StPublish: begin
                    r_h     <= r_wh;
                    r_valid <= 1'b1;
                    // An edge landing on the publish cycle itself is treated as pending.
                    if (r_pending || w_start) begin
                        r_pending <= 1'b0;
                        r_snap    <= w_f;
                        r_idx     <= 4'd0;
                        r_state   <= StProc;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

`ifdef SPECTRUM_PEAK_HOLD_EN
    localparam logic [7:0] HoldFrames = 8'(HOLD_FRAMES);

    logic [15:0][8:0] r_wp;
    logic [15:0][7:0] r_hold;
    logic [15:0][8:0] r_p;
    logic [8:0]       w_wp_old;
    logic [7:0]       w_hold_old;
    logic [8:0]       w_wp_new;
    logic [7:0]       w_hold_new;

    always_comb begin
        w_wp_old   = r_wp[r_idx];
        w_hold_old = r_hold[r_idx];
        w_wp_new   = w_wp_old;
        w_hold_new = w_hold_old;
        if (w_wh_new >= w_wp_old) begin
            w_wp_new   = w_wh_new;
            w_hold_new = HoldFrames;
        end else if (w_hold_old != 8'd0) begin
            w_hold_new = w_hold_old - 8'd1;
        end else if ((w_wp_old - 9'd1) > w_wh_new) begin
            w_wp_new = w_wp_old - 9'd1;
        end else begin
            w_wp_new = w_wh_new;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp   <= '0;
            r_hold <= '0;
            r_p    <= '0;
        end else if (r_state == StProc) begin
            r_wp[r_idx]   <= w_wp_new;
            r_hold[r_idx] <= w_hold_new;
        end else if (r_state == StPublish) begin
            r_p <= r_wp;
        end
    end

    assign w_p = r_p;
`else
    assign w_p = r_h;
`endif

    assign {h15, h14, h13, h12, h11, h10, h9, h8, h7, h6, h5, h4, h3, h2, h1, h0} = r_h;
    assign {p15, p14, p13, p12, p11, p10, p9, p8, p7, p6, p5, p4, p3, p2, p1, p0} = w_p;
    assign valid = r_valid;
    assign busy  = (r_state != StIdle);

endmodule

// File: tb/tb_spectrum_bar_smoother.sv
// Self-checking bench for spectrum_bar_smoother: directed scenarios plus random frames
// compared against a per-frame arithmetic model of the smoothing and peak-hold rules.
module tb_spectrum_bar_smoother;

    localparam int SHIFT       = 12;
    localparam int BAR_MAX     = 448;
    localparam int DECAY       = 4;
    localparam int HOLD_FRAMES = 30;

    logic              clk = 1'b0;
    logic              reset;
    logic              done;
    logic [15:0][23:0] fv;
    logic [15:0][8:0]  hv;
    logic [15:0][8:0]  pv;
    logic              valid;
    logic              busy;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [23:0] m_f    [16];
    int          m_wh   [16];
    int          m_wp   [16];
    int          m_hold [16];

    always #5 clk = ~clk;

    spectrum_bar_smoother #(
        .SHIFT      (SHIFT),
        .BAR_MAX    (BAR_MAX),
        .DECAY      (DECAY),
        .HOLD_FRAMES(HOLD_FRAMES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .done (done),
        .f0 (fv[0]),  .f1 (fv[1]),  .f2 (fv[2]),  .f3 (fv[3]),
        .f4 (fv[4]),  .f5 (fv[5]),  .f6 (fv[6]),  .f7 (fv[7]),
        .f8 (fv[8]),  .f9 (fv[9]),  .f10(fv[10]), .f11(fv[11]),
        .f12(fv[12]), .f13(fv[13]), .f14(fv[14]), .f15(fv[15]),
        .h0 (hv[0]),  .h1 (hv[1]),  .h2 (hv[2]),  .h3 (hv[3]),
        .h4 (hv[4]),  .h5 (hv[5]),  .h6 (hv[6]),  .h7 (hv[7]),
        .h8 (hv[8]),  .h9 (hv[9]),  .h10(hv[10]), .h11(hv[11]),
        .h12(hv[12]), .h13(hv[13]), .h14(hv[14]), .h15(hv[15]),
        .p0 (pv[0]),  .p1 (pv[1]),  .p2 (pv[2]),  .p3 (pv[3]),
        .p4 (pv[4]),  .p5 (pv[5]),  .p6 (pv[6]),  .p7 (pv[7]),
        .p8 (pv[8]),  .p9 (pv[9]),  .p10(pv[10]), .p11(pv[11]),
        .p12(pv[12]), .p13(pv[13]), .p14(pv[14]), .p15(pv[15]),
        .valid(valid),
        .busy (busy)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s_h%0d", tag, i), int'(hv[i]), m_wh[i]);
            check($sformatf("%s_p%0d", tag, i), int'(pv[i]), m_wp[i]);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_wh[i]   = 0;
            m_wp[i]   = 0;
            m_hold[i] = 0;
        end
    endtask

    // One whole frame of the smoothing rules applied to m_f.
    task automatic model_frame();
        int t;
        int wh;
        for (int i = 0; i < 16; i++) begin
            t = int'(m_f[i]) / (1 << SHIFT);
            if (t > BAR_MAX) t = BAR_MAX;
            wh = m_wh[i];
            if (t >= wh) wh = t;
            else begin
                wh = wh - DECAY;
                if (wh < t) wh = t;
            end
            m_wh[i] = wh;
`ifdef SPECTRUM_PEAK_HOLD_EN
            if (wh >= m_wp[i]) begin
                m_wp[i]   = wh;
                m_hold[i] = HOLD_FRAMES;
            end else if (m_hold[i] > 0) begin
                m_hold[i] = m_hold[i] - 1;
            end else begin
                m_wp[i] = m_wp[i] - 1;
                if (m_wp[i] < wh) m_wp[i] = wh;
            end
`else
            m_wp[i] = wh;
`endif
        end
    endtask

    function automatic logic [23:0] rand_bin();
        int sel;
        sel = $urandom_range(0, 3);
        if (sel == 0) return 24'($urandom());
        if (sel == 1) return 24'(0);
        return 24'(($urandom_range(0, BAR_MAX + 40) << SHIFT) | $urandom_range(0, 4095));
    endfunction

    task automatic scramble_inputs();
        for (int i = 0; i < 16; i++) fv[i] = 24'($urandom());
    endtask

    // Drive one done rise with m_f as snapshot, then wait for the publish.
    task automatic run_frame(input string tag);
        int lat;
        bit seen;
        for (int i = 0; i < 16; i++) fv[i] = m_f[i];
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        scramble_inputs();
        model_frame();
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (valid) seen = 1'b1;
        end
        check({tag, "_latency"}, lat, 17);
        check_outputs(tag);
    endtask

    initial begin
        int nv;
        int nbusy;
        int v1;
        int v2;
        logic [23:0] snap [16];

        reset = 1'b1;
        done  = 1'b0;
        fv    = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle after reset: nothing published, never busy.
        nv    = 0;
        nbusy = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clk);
            #1;
            if (valid) nv++;
            if (busy) nbusy++;
        end
        check("idle_valid_count", nv, 0);
        check("idle_busy_count", nbusy, 0);
        check_outputs("reset");

        // Single frame with one mid-range bin.
        for (int i = 0; i < 16; i++) m_f[i] = 24'h0;
        m_f[3] = 24'h064000;
        fv = '0;
        fv[3] = m_f[3];
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        check("busy_after_start", int'(busy), 1);
        scramble_inputs();
        model_frame();
        nv = 0;
        while (!valid && nv < 40) begin
            @(posedge clk);
            #1;
            nv++;
        end
        check("single_latency", nv, 17);
        check_outputs("single");
        check("single_h3_const", int'(hv[3]), 100);
`ifdef SPECTRUM_PEAK_HOLD_EN
        check("single_p3_const", int'(pv[3]), 100);
`endif
        @(posedge clk);
        #1;
        check("valid_one_cycle", int'(valid), 0);
        check("busy_after_publish", int'(busy), 0);

        // Saturation, linear decay and peak hold on bin 0.
        for (int i = 0; i < 16; i++) m_f[i] = rand_bin();
        m_f[0] = 24'hFFFFFF;
        run_frame("sat");
        check("sat_h0_const", int'(hv[0]), 448);
        for (int k = 1; k <= 31; k++) begin
            for (int i = 1; i < 16; i++) m_f[i] = rand_bin();
            m_f[0] = 24'h0;
            run_frame($sformatf("decay%0d", k));
            if (k == 1) check("decay_h0_444", int'(hv[0]), 444);
            if (k == 2) check("decay_h0_440", int'(hv[0]), 440);
`ifdef SPECTRUM_PEAK_HOLD_EN
            if (k == 30) check("hold_p0_448", int'(pv[0]), 448);
            if (k == 31) check("hold_p0_447", int'(pv[0]), 447);
`else
            if (k == 2) check("track_p0_440", int'(pv[0]), 440);
`endif
        end

        // Random frames with random idle gaps between them.
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 16; i++) m_f[i] = rand_bin();
            run_frame($sformatf("rand%0d", k));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        // Overrun: rises at E0, E5, E8; second frame snapshots at the publish edge.
        for (int i = 0; i < 16; i++) m_f[i] = rand_bin();
        for (int i = 0; i < 16; i++) fv[i] = m_f[i];
        done = 1'b1;
        @(posedge clk);
        #1;
        model_frame();
        nv = 0;
        v1 = -1;
        v2 = -1;
        for (int c = 1; c <= 45; c++) begin
            done = (c == 5) || (c == 8);
            for (int i = 0; i < 16; i++) fv[i] = rand_bin();
            if (c == 17) for (int i = 0; i < 16; i++) snap[i] = fv[i];
            @(posedge clk);
            #1;
            if (valid) begin
                nv++;
                if (v1 < 0) v1 = c;
                else if (v2 < 0) v2 = c;
            end
            if (c == 17) check_outputs("ovr_first");
            if (c == 20) check("ovr_busy_pending", int'(busy), 1);
            if (c == 30) check_outputs("ovr_stable");
            if (c == 34) begin
                for (int i = 0; i < 16; i++) m_f[i] = snap[i];
                model_frame();
                check_outputs("ovr_second");
            end
        end
        check("ovr_valid_count", nv, 2);
        check("ovr_first_at", v1, 17);
        check("ovr_second_at", v2, 34);
        check("ovr_idle_busy", int'(busy), 0);

        // Reset sampled at E9 of a frame: abort, clear, no publish.
        for (int i = 0; i < 16; i++) fv[i] = rand_bin();
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        check_outputs("midreset");
        check("midreset_busy", int'(busy), 0);
        check("midreset_valid", int'(valid), 0);
        nv = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (valid) nv++;
        end
        check("midreset_no_valid", nv, 0);
        for (int i = 0; i < 16; i++) m_f[i] = rand_bin();
        run_frame("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
